// File: rtl/ram_write_buffer.sv
// In-order write staging queue in front of the 4R/1W RAM: drains one entry per
// cycle into the RAM write port and forwards pending data onto the read paths.
module ram_write_buffer #(
    parameter int DEPTH  = 16,
    parameter int INDEX  = 4,
    parameter int WIDTH  = 8,
    parameter int QDEPTH = 4,
    parameter int QINDEX = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid_i,
    input  logic [INDEX-1:0]  wr_addr_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    output logic              wr_ready_o,
    input  logic              ram_stall_i,
    output logic [INDEX-1:0]  ram_addr0wr_o,
    output logic              ram_we0_o,
    output logic [WIDTH-1:0]  ram_data0wr_o,
    input  logic [INDEX-1:0]  rd_addr0_i,
    input  logic [INDEX-1:0]  rd_addr1_i,
    input  logic [INDEX-1:0]  rd_addr2_i,
    input  logic [INDEX-1:0]  rd_addr3_i,
    input  logic [WIDTH-1:0]  ram_data0_i,
    input  logic [WIDTH-1:0]  ram_data1_i,
    input  logic [WIDTH-1:0]  ram_data2_i,
    input  logic [WIDTH-1:0]  ram_data3_i,
    output logic [WIDTH-1:0]  rd_data0_o,
    output logic [WIDTH-1:0]  rd_data1_o,
    output logic [WIDTH-1:0]  rd_data2_o,
    output logic [WIDTH-1:0]  rd_data3_o,
    output logic [3:0]        rd_fwd_o,
    output logic [QINDEX:0]   count_o
);

    localparam logic [QINDEX:0]   CNT_ONE  = {{QINDEX{1'b0}}, 1'b1};
    localparam logic [QINDEX:0]   CNT_FULL = (QINDEX+1)'(QDEPTH);
    localparam logic [QINDEX:0]   CNT_ZERO = {(QINDEX+1){1'b0}};
    localparam logic [QINDEX-1:0] PTR_ONE  = {{(QINDEX-1){1'b0}}, 1'b1};
    localparam logic [QINDEX-1:0] PTR_ZERO = {QINDEX{1'b0}};

    if (QDEPTH != (32'd1 << QINDEX) || QDEPTH < 2 || DEPTH > (32'd1 << INDEX)) begin : g_param_check
        $error("ram_write_buffer: inconsistent DEPTH/INDEX/QDEPTH/QINDEX");
    end

    logic [INDEX-1:0]  q_addr_r [QDEPTH];
    logic [WIDTH-1:0]  q_data_r [QDEPTH];
    logic [QINDEX-1:0] head_r;
    logic [QINDEX-1:0] tail_r;
    logic [QINDEX:0]   count_r;

    logic              push_s;
    logic              pop_s;
    logic              ready_s;
    logic [INDEX-1:0]  rd_addr_s [4];
    logic [WIDTH-1:0]  ram_data_s [4];
    logic [WIDTH-1:0]  rd_data_s [4];
    logic [3:0]        fwd_s;
    logic [QINDEX-1:0] slot_s;

    assign rd_addr_s[0]  = rd_addr0_i;
    assign rd_addr_s[1]  = rd_addr1_i;
    assign rd_addr_s[2]  = rd_addr2_i;
    assign rd_addr_s[3]  = rd_addr3_i;
    assign ram_data_s[0] = ram_data0_i;
    assign ram_data_s[1] = ram_data1_i;
    assign ram_data_s[2] = ram_data2_i;
    assign ram_data_s[3] = ram_data3_i;

    // Handshake and drain decisions; ready looks only at registered occupancy.
    always_comb begin
        ready_s = 1'b0;
        pop_s   = 1'b0;
        if (reset) begin
            ready_s = (count_r != CNT_FULL);
            pop_s   = (count_r != CNT_ZERO) && !ram_stall_i;
        end else begin
            ready_s = 1'b0;
            pop_s   = 1'b0;
        end
        push_s = wr_valid_i && ready_s;
    end

    // Head entry presented to the RAM write port, zeroed when the queue is empty.
    always_comb begin
        ram_addr0wr_o = {INDEX{1'b0}};
        ram_data0wr_o = {WIDTH{1'b0}};
        if (count_r != CNT_ZERO) begin
            ram_addr0wr_o = q_addr_r[head_r];
            ram_data0wr_o = q_data_r[head_r];
        end else begin
            ram_addr0wr_o = {INDEX{1'b0}};
            ram_data0wr_o = {WIDTH{1'b0}};
        end
    end

    // Per-read forwarding: scan oldest to youngest so the youngest match wins.
    always_comb begin
        slot_s = PTR_ZERO;
        fwd_s  = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            rd_data_s[k] = ram_data_s[k];
            for (int j = 0; j < QDEPTH; j++) begin
                slot_s = head_r + QINDEX'(j);
                if (reset && ((QINDEX+1)'(j) < count_r) && (q_addr_r[slot_s] == rd_addr_s[k])) begin
                    rd_data_s[k] = q_data_r[slot_s];
                    fwd_s[k]     = 1'b1;
                end else begin
                    fwd_s[k]     = fwd_s[k];
                end
            end
        end
    end

    // Queue storage; contents are don't-care outside the occupied window.
    always_ff @(posedge clk) begin
        if (push_s) begin
            q_addr_r[tail_r] <= wr_addr_i;
            q_data_r[tail_r] <= wr_data_i;
        end
    end

    // Pointer and occupancy update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            head_r  <= PTR_ZERO;
            tail_r  <= PTR_ZERO;
            count_r <= CNT_ZERO;
        end else begin
            if (push_s) begin
                tail_r <= tail_r + PTR_ONE;
            end
            if (pop_s) begin
                head_r <= head_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign wr_ready_o = ready_s;
    assign ram_we0_o  = pop_s;
    assign count_o    = count_r;
    assign rd_fwd_o   = fwd_s;
    assign rd_data0_o = rd_data_s[0];
    assign rd_data1_o = rd_data_s[1];
    assign rd_data2_o = rd_data_s[2];
    assign rd_data3_o = rd_data_s[3];

endmodule

// File: doc/ram_write_buffer.md
Name: ram_write_buffer

Overview:
- Write-side staging queue placed directly upstream of the 4-read/1-write RAM block.
- Accepts (addr, data) writes over a valid/ready handshake and holds them in a small in-order FIFO.
- Drains one entry per cycle into the RAM single write port, unless the RAM write is stalled.
- Forwards pending (not yet retired) write data onto the 4 read paths so readers never see stale RAM contents.

Parameters:
- DEPTH, 16: RAM entry count (passed through for consistency checks).
- INDEX, 4: RAM address width.
- WIDTH, 8: data width.
- QDEPTH, 4: queue entries; must be a power of 2, at least 2.
- QINDEX, 2: log2(QDEPTH).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- wr_valid_i  in  1  upstream write request valid.
- wr_addr_i  in  INDEX  upstream write address.
- wr_data_i  in  WIDTH  upstream write data.
- wr_ready_o  out  1  queue can accept a write this cycle.
- ram_stall_i  in  1  RAM write port unavailable this cycle.
- ram_addr0wr_o  out  INDEX  RAM write address.
- ram_we0_o  out  1  RAM write enable.
- ram_data0wr_o  out  WIDTH  RAM write data.
- rd_addr0_i..rd_addr3_i  in  INDEX each  read addresses, also driven to the RAM read ports.
- ram_data0_i..ram_data3_i  in  WIDTH each  RAM combinational read data.
- rd_data0_o..rd_data3_o  out  WIDTH each  read data after forwarding.
- rd_fwd_o  out  4  bit k = 1 when read k was served from the queue.
- count_o  out  QINDEX+1  number of occupied entries.

Behaviour:
- State: QDEPTH entries of {addr, data}, head pointer, tail pointer (QINDEX bits, wrap modulo QDEPTH), count (QINDEX+1 bits).
- Reset (reset==0 at posedge):
  - head, tail and count go to 0; entry contents are don't-care.
  - While reset is low, wr_ready_o=0 and ram_we0_o=0 combinationally.
  - A write offered during reset is dropped.
  - Reset mid-drain discards all pending entries; no further RAM writes occur.
- Handshake:
  - wr_ready_o = (count != QDEPTH) and reset==1.
  - Ready depends only on registered state; there is no pass-through when full, even if a pop happens that cycle.
  - push = wr_valid_i & wr_ready_o. On push, the entry at tail is written and tail increments.
- Drain:
  - pop = (count != 0) & ~ram_stall_i & reset==1.
  - ram_we0_o = pop. ram_addr0wr_o and ram_data0wr_o come from the head entry.
  - When count==0, ram_addr0wr_o and ram_data0wr_o are 0.
  - The RAM captures the write at the same posedge that head increments.
- Latency: a write pushed at edge N is visible on ram_we0_o in cycle N+1 at the earliest, then retired into the RAM at edge N+1.
- Count update:
  - push & ~pop: count+1.
  - pop & ~push: count-1.
  - push & pop: count unchanged.
  - Push when full is impossible; pop when empty is impossible.
- Forwarding (combinational, per read k independently):
  - Compare rd_addrk_i against every occupied entry, including the head entry being written this cycle.
  - On any match: rd_datak_o = data of the youngest matching entry (closest to tail) and rd_fwd_o[k]=1.
  - Otherwise: rd_datak_o = ram_datak_i and rd_fwd_o[k]=0.
  - An entry being pushed this cycle is NOT forwarded (no same-cycle input bypass).
  - Unoccupied slots never match, including after pointer wrap-around.
- Duplicate addresses in the queue are legal. They retire in order, and the RAM ends holding the youngest value.
- While reset is low: rd_fwd_o=0 and rd_datak_o=ram_datak_i.
- Outputs after reset: wr_ready_o=1, ram_we0_o=0, count_o=0, rd_fwd_o=0.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles while wr_valid_i=1 -> wr_ready_o=0, ram_we0_o=0; after release count_o=0, wr_ready_o=1, no write reaches the RAM.
- Single write: push addr=3 data=0xA5 at edge N -> cycle N+1 shows ram_we0_o=1, addr 3, data 0xA5, rd_fwd_o[0]=1 with rd_data0_o=0xA5 for rd_addr0_i=3; cycle N+2 shows count_o=0 and the RAM read returns 0xA5.
- Fill under stall: ram_stall_i=1, push addr 1..4 with data 0x11..0x44 -> count_o=4, wr_ready_o=0, a 5th offer is not accepted; release the stall -> 4 RAM writes in order, one per cycle.
- Youngest-wins forwarding: stall, push (5,0x10) then (5,0x20); read addr 5 on all 4 ports -> all rd_data=0x20 and rd_fwd_o=4'b1111; after draining, RAM[5]=0x20.
- Simultaneous push/pop at count=2 -> count_o stays 2; run 12 writes continuously to exercise head/tail wrap -> every write retires in order and no stale slot forwards.
- Reset mid-drain: stall with 3 entries, assert reset for 1 cycle -> count_o=0 and no RAM writes; forwarding is off and rd_data follows ram_data.
